// File: rtl/eim_pkg.sv
// Purpose : shared types and constants for the EIM bus bridge.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package eim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_REQ,
    RD_REQ,
    RD_RSP,
    RD_DRIVE
  } eim_state_t;

  // EIM control strobes are active low, so "idle" is a high level.
  localparam logic       EIM_CTRL_IDLE    = 1'b1;
  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/eim_sync.sv
// Purpose : STAGES-deep flop synchroniser for a WIDTH-bit asynchronous input.
// Latency : STAGES clk cycles from d to q.
// Backpr. : none; free-running.
// Ports   : clk, rst (async active-high), d (raw input), q (synchronised output).
module eim_sync #(
  parameter int                 WIDTH     = 1,
  parameter int                 STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/eim_bus_bridge.sv
// Purpose : converts i.MX6 EIM cycles (muxed 8-bit A/D) into single valid/ready
//           requests, stalls CPU reads via eim_wait_n and steers the BBPD tristate.
// Latency : raw pin change -> SYNC_STAGES sync flops -> 1 registered output cycle.
// Backpr. : req_valid/payload held until req_ready; reads hold eim_wait_n low until
//           response or TIMEOUT_CYCLES; a new EIM cycle during a pending write is
//           dropped and flagged on err_overrun.
// Ports   : clk/rst; eim_cs0_n/lba_n/wr_n/oe_n + da_in (raw EIM); da_out/da_t (BBPD);
//           eim_wait_n; req_* (request bus); rsp_* (read response); err_timeout/overrun.
module eim_bus_bridge
  import eim_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eim_cs0_n,
  input  logic       eim_lba_n,
  input  logic       eim_wr_n,
  input  logic       eim_oe_n,
  input  logic [7:0] da_in,
  output logic [7:0] da_out,
  output logic       da_t,
  output logic       eim_wait_n,
  output logic       req_valid,
  input  logic       req_ready,
  output logic       req_we,
  output logic [7:0] req_addr,
  output logic [7:0] req_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  // Control bits packed as {cs, lba, wr, oe}.
  logic [3:0] ctrl_s;
  logic [7:0] da_s;
  logic       cs_s, lba_s, wr_s, oe_s;

  eim_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VAL({4{EIM_CTRL_IDLE}})) u_sync_ctrl (
    .clk (clk),
    .rst (rst),
    .d   ({eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n}),
    .q   (ctrl_s)
  );

  eim_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RESET_VAL(8'h00)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d   (da_in),
    .q   (da_s)
  );

  assign {cs_s, lba_s, wr_s, oe_s} = ctrl_s;

  logic [3:0] ctrl_prev_q, ctrl_prev_d;
  logic       cs_rise, lba_fall, wr_rise, oe_rise;

  assign ctrl_prev_d = ctrl_s;
  assign cs_rise  = !ctrl_prev_q[3] &&  cs_s;
  assign lba_fall =  ctrl_prev_q[2] && !lba_s;
  assign wr_rise  = !ctrl_prev_q[1] &&  wr_s;
  assign oe_rise  = !ctrl_prev_q[0] &&  oe_s;

  eim_state_t       state_q, state_d;
  logic [7:0]       da_out_q, da_out_d;
  logic             da_t_q, da_t_d;
  logic             eim_wait_n_q, eim_wait_n_d;
  logic             req_valid_q, req_valid_d;
  logic             req_we_q, req_we_d;
  logic [7:0]       req_addr_q, req_addr_d;
  logic [7:0]       req_wdata_q, req_wdata_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // late_q: this read already timed out, so any response is discarded.
  logic             late_q, late_d;

  logic             in_read;
  logic [CNT_W-1:0] cnt_inc;
  logic             to_fire;

  assign in_read = (state_q == RD_REQ) || (state_q == RD_RSP);
  assign cnt_inc = cnt_q + 1'b1;
  // Fires on the cycle the counter steps onto TIMEOUT_CYCLES, once per read.
  assign to_fire = in_read && !late_q && (cnt_q != CNT_MAX) && (cnt_inc == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    da_out_d      = da_out_q;
    da_t_d        = cs_s || oe_s;
    eim_wait_n_d  = eim_wait_n_q;
    req_valid_d   = req_valid_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    err_timeout_d = 1'b0;
    err_overrun_d = err_overrun_q;
    cnt_d         = cnt_q;
    late_d        = late_q;

    if (in_read && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_inc;
    end

    case (state_q)
      IDLE: begin
        if (lba_fall && !cs_s) begin
          req_addr_d = da_s;
          if (wr_s) begin
            state_d      = RD_REQ;
            req_valid_d  = 1'b1;
            req_we_d     = 1'b0;
            eim_wait_n_d = 1'b0;
            cnt_d        = '0;
            late_d       = 1'b0;
          end else begin
            state_d = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (wr_rise) begin
          req_wdata_d = da_s;
          req_valid_d = 1'b1;
          req_we_d    = 1'b1;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: begin
        if (lba_fall) begin
          err_overrun_d = 1'b1;
        end
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      RD_REQ: begin
        if (to_fire) begin
          da_out_d      = ERR_DATA;
          eim_wait_n_d  = 1'b1;
          err_timeout_d = 1'b1;
          late_d        = 1'b1;
        end
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = (late_q || to_fire) ? RD_DRIVE : RD_RSP;
        end
      end
      RD_RSP: begin
        if (rsp_valid) begin
          da_out_d     = rsp_rdata;
          eim_wait_n_d = 1'b1;
          state_d      = RD_DRIVE;
        end else if (to_fire) begin
          da_out_d      = ERR_DATA;
          eim_wait_n_d  = 1'b1;
          err_timeout_d = 1'b1;
          late_d        = 1'b1;
          state_d       = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (oe_rise || cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_prev_q   <= {4{EIM_CTRL_IDLE}};
      state_q       <= IDLE;
      da_out_q      <= 8'h00;
      da_t_q        <= 1'b1;
      eim_wait_n_q  <= 1'b1;
      req_valid_q   <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= 8'h00;
      req_wdata_q   <= 8'h00;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      cnt_q         <= '0;
      late_q        <= 1'b0;
    end else begin
      ctrl_prev_q   <= ctrl_prev_d;
      state_q       <= state_d;
      da_out_q      <= da_out_d;
      da_t_q        <= da_t_d;
      eim_wait_n_q  <= eim_wait_n_d;
      req_valid_q   <= req_valid_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      cnt_q         <= cnt_d;
      late_q        <= late_d;
    end
  end

  assign da_out      = da_out_q;
  assign da_t        = da_t_q;
  assign eim_wait_n  = eim_wait_n_q;
  assign req_valid   = req_valid_q;
  assign req_we      = req_we_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_eim_bus_bridge.sv
// Purpose : directed self-checking bench for eim_bus_bridge (TIMEOUT_CYCLES=8).
// Latency : inputs driven 1ns after posedge, outputs sampled at the same point.
// Backpr. : req_ready / rsp_valid driven directly by the bench.
module tb_eim_bus_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n;
  logic [7:0] da_in;
  logic [7:0] da_out;
  logic       da_t, eim_wait_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       err_timeout, err_overrun;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  eim_bus_bridge #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .eim_cs0_n  (eim_cs0_n),
    .eim_lba_n  (eim_lba_n),
    .eim_wr_n   (eim_wr_n),
    .eim_oe_n   (eim_oe_n),
    .da_in      (da_in),
    .da_out     (da_out),
    .da_t       (da_t),
    .eim_wait_n (eim_wait_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for req_valid; returns at the first sample where it is high.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (req_valid) ok = 1'b1;
    end
  endtask

  task automatic start_cycle(input logic wr_n, input logic [7:0] addr);
    eim_cs0_n = 1'b0;
    eim_wr_n  = wr_n;
    da_in     = addr;
    tick(3);
    eim_lba_n = 1'b0;
  endtask

  initial begin
    bit         ok;
    int         n, lo, pulses, bad;
    logic [7:0] cap_addr, cap_wdata;
    logic       cap_we;

    rst = 1'b1;
    eim_cs0_n = 1'b1; eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
    da_in = 8'h00; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 8'h00;
    tick(3);
    chk("rst_da_t", da_t, 1);
    chk("rst_wait_n", eim_wait_n, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_da_out", da_out, 8'h00);
    chk("rst_misc", {req_we, req_addr, req_wdata, err_timeout, err_overrun}, 0);
    rst = 1'b0;
    tick(3);

    // ---- write: addr 10, data A5, req_ready already high ----
    start_cycle(1'b0, 8'h10);
    tick(4);
    eim_lba_n = 1'b1; da_in = 8'hA5; eim_wr_n = 1'b1; req_ready = 1'b1;
    n = 0; lo = 0; cap_addr = 0; cap_wdata = 0; cap_we = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_valid) begin
        n++; cap_addr = req_addr; cap_wdata = req_wdata; cap_we = req_we;
      end
      if (!eim_wait_n) lo++;
    end
    req_ready = 1'b0;
    chk("wr_req_count", n, 1);
    chk("wr_we", cap_we, 1);
    chk("wr_addr", cap_addr, 8'h10);
    chk("wr_wdata", cap_wdata, 8'hA5);
    chk("wr_wait_low_cycles", lo, 0);
    eim_cs0_n = 1'b1;
    tick(4);

    // ---- read: addr 03, ready on 3rd cycle, response 5C four cycles later ----
    start_cycle(1'b1, 8'h03);
    wait_req(ok);
    chk("rd_req_seen", ok, 1);
    chk("rd_addr_we", {req_addr, req_we}, {8'h03, 1'b0});
    chk("rd_wait_low_at_req", eim_wait_n, 0);
    tick(2);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("rd_valid_dropped", req_valid, 0);
    eim_lba_n = 1'b1; eim_oe_n = 1'b0;
    tick(3);
    chk("rd_wait_low_before_rsp", eim_wait_n, 0);
    rsp_valid = 1'b1; rsp_rdata = 8'h5C;
    tick();
    rsp_valid = 1'b0;
    chk("rd_wait_released", eim_wait_n, 1);
    chk("rd_da_out", da_out, 8'h5C);
    chk("rd_da_t_driving", da_t, 0);
    eim_oe_n = 1'b1;
    tick(4);
    chk("rd_da_t_released", da_t, 1);
    rsp_valid = 1'b1; rsp_rdata = 8'h77;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("rd_stray_rsp_ignored", da_out, 8'h5C);
    eim_cs0_n = 1'b1;
    tick(4);

    // ---- timeout in RD_RSP: accepted at once, no response ever ----
    eim_oe_n = 1'b0;
    start_cycle(1'b1, 8'h40);
    wait_req(ok);
    chk("to_rsp_req_seen", ok, 1);
    req_ready = 1'b1;
    lo = eim_wait_n ? 0 : 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      req_ready = 1'b0;
      if (!eim_wait_n) lo++;
      if (err_timeout) pulses++;
    end
    chk("to_rsp_wait_low_cycles", lo, 8);
    chk("to_rsp_err_pulses", pulses, 1);
    chk("to_rsp_da_out", da_out, 8'hFF);
    chk("to_rsp_wait_n", eim_wait_n, 1);
    eim_lba_n = 1'b1; eim_oe_n = 1'b1;
    tick(3);
    eim_cs0_n = 1'b1;
    tick(4);

    // ---- timeout in RD_REQ: request never retracted, late response dropped ----
    eim_oe_n = 1'b0;
    start_cycle(1'b1, 8'h41);
    wait_req(ok);
    chk("to_req_req_seen", ok, 1);
    lo = eim_wait_n ? 0 : 1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!eim_wait_n) lo++;
      if (err_timeout) pulses++;
    end
    chk("to_req_wait_low_cycles", lo, 8);
    chk("to_req_err_pulses", pulses, 1);
    chk("to_req_valid_held", req_valid, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("to_req_handshake", req_valid, 0);
    rsp_valid = 1'b1; rsp_rdata = 8'h33;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("to_req_late_rsp_dropped", da_out, 8'hFF);
    eim_lba_n = 1'b1; eim_oe_n = 1'b1;
    tick(3);
    eim_cs0_n = 1'b1;
    tick(4);

    // ---- backpressure + overrun ----
    start_cycle(1'b0, 8'h20);
    tick(4);
    eim_lba_n = 1'b1; eim_wr_n = 1'b1; da_in = 8'hB7;
    wait_req(ok);
    chk("ov_req_seen", ok, 1);
    chk("ov_payload", {req_we, req_addr, req_wdata}, {1'b1, 8'h20, 8'hB7});
    eim_wr_n = 1'b0; da_in = 8'h99; eim_lba_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!req_valid || !req_we || req_addr != 8'h20 || req_wdata != 8'hB7) bad++;
    end
    chk("ov_payload_stable", bad, 0);
    chk("ov_err_overrun", err_overrun, 1);
    req_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_valid) n++;
      tick();
    end
    req_ready = 1'b0;
    chk("ov_single_request", n, 1);
    chk("ov_err_sticky", err_overrun, 1);
    eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_cs0_n = 1'b1;
    tick(4);

    // ---- CS guard: LBA falls with CS high ----
    eim_cs0_n = 1'b1; eim_wr_n = 1'b0; da_in = 8'h55;
    tick(3);
    eim_lba_n = 1'b0;
    tick(4);
    eim_lba_n = 1'b1; eim_wr_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_valid) n++;
    end
    chk("cs_guard_no_req", n, 0);

    // ---- CS rise aborts a write in WR_DATA ----
    start_cycle(1'b0, 8'h66);
    tick(4);
    eim_lba_n = 1'b1; eim_cs0_n = 1'b1;
    tick(4);
    eim_wr_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_valid) n++;
    end
    chk("cs_abort_no_req", n, 0);

    // ---- async reset while in RD_RSP ----
    eim_oe_n = 1'b0;
    start_cycle(1'b1, 8'h12);
    wait_req(ok);
    chk("ar_req_seen", ok, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick(3);
    chk("ar_pre_state", {eim_wait_n, da_t, err_overrun}, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wait_n", eim_wait_n, 1);
    chk("ar_da_t", da_t, 1);
    chk("ar_outputs", {req_valid, req_we, req_addr, req_wdata, da_out, err_timeout, err_overrun}, 0);
    eim_cs0_n = 1'b1; eim_lba_n = 1'b1; eim_wr_n = 1'b1; eim_oe_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eim_bus_bridge.md
Name: eim_bus_bridge

Overview:
Front-end between raw i.MX6 EIM pins (8-bit multiplexed address/data, active-low LBA/WR/OE/CS0) and the on-chip memory/register stage. It synchronises all EIM inputs into the system clock domain and detects LBA/WR/OE/CS edges. It converts each EIM cycle into a single valid/ready request on an internal bus, drives eim_wait_n to stall CPU reads until response data exists, and controls the BBPD tristate for the data bus.

Parameters:
SYNC_STAGES, 2, synchroniser depth for every EIM input (>=2)
TIMEOUT_CYCLES, 64, max clk cycles a read may hold eim_wait_n low
ERR_DATA, 8'hFF, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
eim_cs0_n  in  1  raw chip select
eim_lba_n  in  1  raw address latch
eim_wr_n  in  1  raw write enable
eim_oe_n  in  1  raw output enable
da_in  in  8  data bus from BBPD O pins
da_out  out  8  data to BBPD I pins
da_t  out  1  BBPD T; 1 = high-Z
eim_wait_n  out  1  CPU wait, active low
req_valid  out  1  request valid
req_ready  in  1  downstream accepts request
req_we  out  1  1 = write, 0 = read
req_addr  out  8  request address
req_wdata  out  8  write data
rsp_valid  in  1  read data valid (single-cycle pulse)
rsp_rdata  in  8  read data
err_timeout  out  1  one-cycle pulse on read timeout
err_overrun  out  1  sticky; new EIM cycle arrived while a write request was pending

Behaviour:
- Interface: one clock clk; reset rst is asynchronous, active-high. All outputs are registered.
- Reset values: da_out=0, da_t=1, eim_wait_n=1, req_valid=0, req_we=0, req_addr=0, req_wdata=0, err_timeout=0, err_overrun=0, state=IDLE. Synchroniser flops reset to 1 for control inputs and 0 for data.
- Synchronisation: all inputs pass SYNC_STAGES flops (_s suffix). Edges are detected against a one-cycle-delayed copy of the _s signal.
- da_t=0 exactly when cs_s==0 and oe_s==0, independent of state. This is one registered cycle after the synced condition.
- FSM states: IDLE, WR_DATA, WR_REQ, RD_REQ, RD_RSP, RD_DRIVE.
- IDLE: on LBA falling edge with cs_s==0, latch req_addr=da_s.
  - If wr_s==1, go to RD_REQ. On the same clock, req_valid=1, req_we=0, eim_wait_n=0.
  - Otherwise go to WR_DATA.
  - LBA falling edge with cs_s==1 is ignored.
- WR_DATA: on WR rising edge, req_wdata=da_s, req_valid=1, req_we=1, go to WR_REQ. A CS rising edge first aborts to IDLE with no request.
- WR_REQ: hold req_valid and all payload stable until req_valid&&req_ready, then deassert and go to IDLE.
  - An LBA falling edge in WR_REQ sets err_overrun; that cycle is dropped.
  - eim_wait_n stays 1 for writes.
- RD_REQ: hold until handshake, then go to RD_RSP. req_valid is never retracted, even if CS rises.
- RD_RSP: on rsp_valid, da_out=rsp_rdata, eim_wait_n=1, go to RD_DRIVE. rsp_valid in any other state is ignored.
- Timeout: a counter runs from entry to RD_REQ.
  - When it reaches TIMEOUT_CYCLES in RD_RSP: da_out=ERR_DATA, eim_wait_n=1, pulse err_timeout, go to RD_DRIVE.
  - In RD_REQ the timeout releases eim_wait_n and pulses err_timeout, but the request handshake still completes. The late response is then discarded (RD_RSP is skipped; go to RD_DRIVE).
  - Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- RD_DRIVE: hold da_out until an OE rising edge or CS rising edge, then go to IDLE.
- Handshake happening in the same cycle as its entry: not possible. req_valid is registered, so the earliest acceptance is the cycle after assertion.
- Reset mid-transaction: immediate return to reset values. No request is completed.

Decomposition:
- Package eim_pkg: state enum eim_state_t, EIM_CTRL_IDLE = 1'b1 constant, default ERR_DATA.
- One sub-module, eim_sync: parameterised WIDTH/STAGES/RESET_VAL synchroniser with async active-high reset. It is instantiated twice: once for control, once for data.

Test Plan:
- Write: CS low, LBA fall with da=8'h10 and WR low, then WR rise with da=8'hA5, req_ready=1 → one req_valid cycle, we=1, addr=8'h10, wdata=8'hA5; eim_wait_n stays 1.
- Read: LBA fall with da=8'h03 and WR high; req_ready after 3 cycles; rsp_valid with 8'h5C 4 cycles later; OE low → eim_wait_n low from request until response, then da_out=8'h5C and da_t=0 while OE is low; da_t=1 after OE rises.
- Timeout: read with rsp_valid never asserted, TIMEOUT_CYCLES=8 → after 8 cycles eim_wait_n=1, err_timeout pulses once, da_out=8'hFF.
- Backpressure/overrun: write held with req_ready=0, then a second LBA fall → payload stable throughout, err_overrun=1 and sticky, exactly one request issued.
- CS guard/abort: LBA fall with CS high → no request; CS rise in WR_DATA → IDLE, no request.
- Async reset asserted in RD_RSP → all outputs at reset values with no clock edge; eim_wait_n=1, da_t=1.
